symbol_transmitter: RTL and testbench
=====================================

// Module: symbol_transmitter
// PURPOSE
//  Baseband transmit path of the comm link. Captures 16-bit signed symbols on a read strobe and
//  upsamples them to the clock rate: strobe cycles insert the symbol, other cycles insert zero.
//  A fixed 7-tap symmetric FIR pulse-shapes the stream, and the shaped samples go to the DAC path.
//  Sits between the symbol mapper and the DAC interface.
// PARAMETERS
//  DATA_W  16  width of symb_in/symb_out (signed two's complement)
//  SHIFT   5   arithmetic right shift applied to the FIR accumulator (gain normalisation)
// PORTS
//  clk       in   1       clock; all logic on rising edge
//  reset     in   1       synchronous, active-low reset (asserted when 0, sampled on clk)
//  symb_in   in   DATA_W  signed input symbol; valid only when read=1
//  read      in   1       capture strobe; symbol taken on the rising edge where read=1
//  symb_out  out  DATA_W  signed shaped output sample, registered, updated every cycle
// BEHAVIOUR
//  - Coefficients (localparam, unsigned): c0..c6 = 1,3,6,8,6,3,1 (sum 28).
//  - Delay line d0..d6 (DATA_W signed). Each edge (reset=1): d(i)<=d(i-1); d0<=read ? symb_in : 0.
//  - Accumulator: acc = sum ci*di, signed, >= DATA_W+5 bits wide (21 for default); no overflow possible.
//  - Output register, each edge: symb_out <= acc >>> SHIFT, using the delay line after the
//    previous edge. Floor rounding (arithmetic shift). Truncate to DATA_W with no saturation;
//    |result| < 2^15 by construction.
//  - Latency: symbol captured at edge k gives c0 term at edge k+1, and c6 term at edge k+7.
//    Impulse response spans 7 cycles.
//  - Back-to-back reads, including consecutive cycles, are legal. Contributions superpose linearly.
//  - No handshake or back-pressure. read is never refused.
//  - Reset (reset=0 at an edge): clear d0..d6, hold register and symb_out to 0.
//    read/symb_in are ignored during that edge.
//  - Reset mid-pulse discards all in-flight contributions. After reset releases, symb_out stays 0
//    until a new symbol propagates.
//  - X/undriven symb_in is never sampled when read=0.
// CONFIGURATION
//  TX_HOLD_EN defined:
//   - Sample-and-hold upsampling: a hold register captures symb_in when read=1.
//   - Cycles with read=0 push the held symbol into d0 instead of zero. The hold register is 0
//     after reset.
//   - DC gain becomes 28/32 of the held value in steady state.
//  TX_HOLD_EN undefined:
//   - Zero-stuffing as above; no hold register is synthesised.
// TESTING (default build, TX_HOLD_EN undefined unless noted)
//  1. Reset 0 for 1 cycle, then idle, read=0
//     -> symb_out stays 0 on every edge.
//  2. One read with symb_in=32 at edge k
//     -> symb_out = 1,3,6,8,6,3,1 at edges k+1..k+7, then 0.
//  3. One read with symb_in=-1
//     -> symb_out = -1 for 7 consecutive edges (floor), then 0.
//  4. One read with symb_in=16'h7FFF
//     -> peak symb_out = 8191 at edge k+4. No wrap.
//  5. read=1 one cycle in three, symb_in=16'h16A1 (5793), repeated 10 times
//     -> steady-state pattern 1810,1629,1629 repeating.
//     -> Then decays to 0 within 7 cycles of the last read.
//  6. Reset asserted mid-pulse of test 2
//     -> symb_out=0 on the next edge and after.
//  7. TX_HOLD_EN defined, single read symb_in=32
//     -> symb_out ramps 1,4,10,18,24,27 and then stays at 28.

Source files
------------

// File: rtl/symbol_transmitter_if.sv
// Symbol bus between the symbol mapper (master) and the transmit pulse shaper (slave).
// symb_in/read carry captured symbols in; symb_out carries shaped samples to the DAC path.
interface symbol_transmitter_if #(
  parameter int unsigned DATA_W = 16
);
  logic signed [DATA_W-1:0] symb_in;
  logic                     read;
  logic signed [DATA_W-1:0] symb_out;

  modport master (
    output symb_in,
    output read,
    input  symb_out
  );

  modport slave (
    input  symb_in,
    input  read,
    output symb_out
  );
endinterface

// File: rtl/symbol_transmitter.sv
// Baseband transmit pulse shaper: upsamples strobed symbols to the clock rate and filters them
// through a fixed 7-tap symmetric FIR (1,3,6,8,6,3,1), normalised by an arithmetic shift.
// Optional macro TX_HOLD_EN: sample-and-hold upsampling instead of zero-stuffing.
module symbol_transmitter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SHIFT  = 5
) (
  input logic                 clk,
  input logic                 reset,
  symbol_transmitter_if.slave bus
);
  localparam int unsigned Taps = 7;
  // Coefficient sum is 28 < 32, so 5 guard bits above the sample width cannot overflow.
  localparam int unsigned AccW = DATA_W + 5;
  // Packed as {c6..c0} so that Coef[i] is ci.
  localparam logic [Taps-1:0][3:0] Coef = {4'd1, 4'd3, 4'd6, 4'd8, 4'd6, 4'd3, 4'd1};

  logic signed [DATA_W-1:0] d_q [Taps];
  logic signed [DATA_W-1:0] d_d [Taps];
  logic signed [DATA_W-1:0] symb_out_q;
  logic signed [DATA_W-1:0] symb_out_d;
  logic signed [DATA_W-1:0] insert;
  logic signed [AccW-1:0]   acc;
  logic signed [AccW-1:0]   acc_sh;
  logic                     unused_acc_sh;

`ifdef TX_HOLD_EN
  logic signed [DATA_W-1:0] hold_q;
  logic signed [DATA_W-1:0] hold_d;

  // Hold register follows the strobed symbol; idle cycles repeat the last one.
  always_comb begin
    hold_d = hold_q;
    if (bus.read) begin
      hold_d = bus.symb_in;
    end
    insert = hold_d;
  end

  // Hold register state, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Zero-stuffing: symb_in is only looked at when read is high.
  always_comb begin
    insert = '0;
    if (bus.read) begin
      insert = bus.symb_in;
    end
  end
`endif

  // Delay line shift with the new upsampled value entering at d0.
  always_comb begin
    d_d[0] = insert;
    for (int i = 1; i < Taps; i++) begin
      d_d[i] = d_q[i-1];
    end
  end

  // FIR sum over the current delay line, then floor-normalise and truncate.
  always_comb begin
    acc = '0;
    for (int i = 0; i < Taps; i++) begin
      acc = acc + AccW'(d_q[i]) * $signed({{(AccW-4){1'b0}}, Coef[i]});
    end
    acc_sh     = acc >>> SHIFT;
    symb_out_d = acc_sh[DATA_W-1:0];
  end

  // Upper bits are sign copies after normalisation; nothing to saturate.
  assign unused_acc_sh = ^acc_sh[AccW-1:DATA_W];

  // Delay line and output register; reset drops all in-flight contributions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_q        <= '{default: '0};
      symb_out_q <= '0;
    end else begin
      d_q        <= d_d;
      symb_out_q <= symb_out_d;
    end
  end

  assign bus.symb_out = symb_out_q;
endmodule

// File: tb/tb_symbol_transmitter.sv
// Bench for symbol_transmitter: directed literal checks plus randomized traffic compared every
// cycle against a convolution model built from a per-edge record of inserted samples.
module tb_symbol_transmitter;
  logic clk = 1'b0;
  logic reset;

  symbol_transmitter_if #(.DATA_W(16)) bus_if ();

  symbol_transmitter #(
    .DATA_W(16),
    .SHIFT (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam int Coef [7] = '{1, 3, 6, 8, 6, 3, 1};

  // Value entering the pulse shaper on each edge, indexed by edge number.
  int ins [0:8191];
  int nedge    = 0;
  int rst_edge = 0;
  bit started  = 1'b0;
  int hold_m   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output at edge n = floor(sum_j c_j * x[n-1-j] / 32), ignoring samples at or before a reset.
  always @(posedge clk) begin
    int e;
    int idx;
    e = 0;
    if (reset === 1'b0) begin
      started  = 1'b1;
      rst_edge = nedge;
      hold_m   = 0;
      ins[nedge] = 0;
    end else begin
      for (int j = 0; j < 7; j++) begin
        idx = nedge - 1 - j;
        if (started && idx > rst_edge) e += Coef[j] * ins[idx];
      end
      if (bus_if.read === 1'b1) begin
        ins[nedge] = int'(bus_if.symb_in);
        hold_m     = ins[nedge];
      end else begin
`ifdef TX_HOLD_EN
        ins[nedge] = hold_m;
`else
        ins[nedge] = 0;
`endif
      end
    end
    e = e >>> 5;
    #1;
    if (started) check("model", int'(bus_if.symb_out), e);
    nedge++;
  end

  // One clock: drive on the falling edge, return shortly after the rising edge.
  task automatic cyc(input bit rst_n, input bit rd, input int v);
    @(negedge clk);
    reset          = rst_n;
    bus_if.read    = rd;
    bus_if.symb_in = 16'(v);
    @(posedge clk);
    #2;
  endtask

  function automatic int out_val();
    return int'(bus_if.symb_out);
  endfunction

  initial begin
    int p [9];
    int v;
    reset          = 1'b0;
    bus_if.read    = 1'b0;
    bus_if.symb_in = '0;

    cyc(0, 0, 0);
    cyc(0, 1, 123);
    check("reset_out", out_val(), 0);

`ifdef TX_HOLD_EN
    // Held symbol of 32 accumulates the running coefficient sum.
    p = '{1, 4, 10, 18, 24, 27, 28, 28, 28};
    cyc(1, 1, 32);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 0);
      check("hold_ramp", out_val(), p[i]);
    end
    cyc(0, 0, 0);
    check("hold_reset", out_val(), 0);
    cyc(1, 0, 0);
    check("hold_cleared", out_val(), 0);
`else
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0);
      check("idle", out_val(), 0);
    end

    p = '{1, 3, 6, 8, 6, 3, 1, 0, 0};
    cyc(1, 1, 32);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 0);
      check("pulse32", out_val(), p[i]);
    end

    cyc(1, 1, -1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      check("pulse_m1", out_val(), (i < 7) ? -1 : 0);
    end

    cyc(1, 1, 32767);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      if (i == 3) check("peak_max", out_val(), 8191);
    end
    check("peak_tail", out_val(), 0);

    // One read in three of 5793 settles into 1629,1810,1629.
    for (int r = 0; r < 10; r++) begin
      cyc(1, 1, 5793);
      if (r >= 3) check("periodic0", out_val(), 1629);
      cyc(1, 0, 0);
      if (r >= 3) check("periodic1", out_val(), 1810);
      cyc(1, 0, 0);
      if (r >= 3) check("periodic2", out_val(), 1629);
    end
    for (int i = 0; i < 6; i++) cyc(1, 0, 0);
    check("periodic_decay", out_val(), 0);

    // Reset in the middle of a pulse.
    cyc(1, 1, 32);
    cyc(1, 0, 0);
    check("midpulse1", out_val(), 1);
    cyc(1, 0, 0);
    check("midpulse2", out_val(), 3);
    cyc(0, 1, 500);
    check("midpulse_rst", out_val(), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      check("after_rst", out_val(), 0);
    end
`endif

    // Randomized traffic, occasional resets and full-scale symbols.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       v = 32767;
        1:       v = -32768;
        default: v = int'($signed(16'($urandom)));
      endcase
      cyc(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), v);
    end
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
